// File: rtl/enigma_config_ctrl.sv
// Turns debounced ENTER/LDPlug/LDRot levels into single events and sequences plugboard
// pair entry, rotor start-position loading and encrypt requests; all outputs registered.
module enigma_config_ctrl #(
    parameter int NUM_ROT   = 3,
    parameter int MAX_PAIRS = 10
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [4:0] LET,
    input  logic       ENTER,
    input  logic       LDPlug,
    input  logic       LDRot,
    output logic       plugClr,
    output logic       plugWE,
    output logic [4:0] plugA,
    output logic [4:0] plugB,
    output logic       rotWE,
    output logic [1:0] rotSel,
    output logic [4:0] rotPos,
    output logic       encStrobe,
    output logic [4:0] encLet,
    output logic [2:0] mode,
    output logic [3:0] pairCnt,
    output logic       err
);
    localparam logic [2:0] S_IDLE        = 3'd0;
    localparam logic [2:0] S_PLUG_FIRST  = 3'd1;
    localparam logic [2:0] S_PLUG_SECOND = 3'd2;
    localparam logic [2:0] S_ROT_LOAD    = 3'd3;
    localparam logic [2:0] S_RUN         = 3'd4;
    localparam logic [1:0] LAST_ROT      = 2'(NUM_ROT - 1);
    localparam logic [3:0] MAX_CNT       = 4'(MAX_PAIRS);

    logic [2:0]  prev_q, prev_d;
    logic [2:0]  state_q, state_d;
    logic [25:0] used_q, used_d;
    logic [1:0]  rot_idx_q, rot_idx_d;
    logic        rot_loaded_q, rot_loaded_d;
    logic [4:0]  first_q, first_d;
    logic [3:0]  pair_cnt_q, pair_cnt_d;
    logic        plug_clr_q, plug_clr_d, plug_we_q, plug_we_d;
    logic [4:0]  plug_a_q, plug_a_d, plug_b_q, plug_b_d;
    logic        rot_we_q, rot_we_d;
    logic [1:0]  rot_sel_q, rot_sel_d;
    logic [4:0]  rot_pos_q, rot_pos_d;
    logic        enc_q, enc_d;
    logic [4:0]  enc_let_q, enc_let_d;
    logic        err_q, err_d;

    logic        ev_ent, ev_plug, ev_rot, let_used;
    logic [25:0] let_bit, first_bit;
    logic [3:0]  cnt_inc;
    logic [2:0]  exit_state;

    assign ev_ent     = ENTER  & ~prev_q[0];
    assign ev_plug    = LDPlug & ~prev_q[1];
    assign ev_rot     = LDRot  & ~prev_q[2];
    assign let_bit    = 26'd1 << LET;
    assign first_bit  = 26'd1 << first_q;
    assign let_used   = |(used_q & let_bit);
    assign cnt_inc    = pair_cnt_q + 4'd1;
    assign exit_state = rot_loaded_q ? S_RUN : S_IDLE;

    always_comb begin
        prev_d       = {LDRot, LDPlug, ENTER};
        state_d      = state_q;
        used_d       = used_q;
        rot_idx_d    = rot_idx_q;
        rot_loaded_d = rot_loaded_q;
        first_d      = first_q;
        pair_cnt_d   = pair_cnt_q;
        plug_clr_d   = 1'b0;
        plug_we_d    = 1'b0;
        plug_a_d     = plug_a_q;
        plug_b_d     = plug_b_q;
        rot_we_d     = 1'b0;
        rot_sel_d    = rot_sel_q;
        rot_pos_d    = rot_pos_q;
        enc_d        = 1'b0;
        enc_let_d    = enc_let_q;
        err_d        = 1'b0;

        // Priority LDRot > LDPlug > ENTER; losers on the same edge are dropped.
        if (ev_rot) begin
            state_d   = S_ROT_LOAD;
            rot_idx_d = 2'd0;
        end else if (ev_plug) begin
            case (state_q)
                S_IDLE, S_RUN: begin
                    state_d    = S_PLUG_FIRST;
                    plug_clr_d = 1'b1;
                    used_d     = '0;
                    pair_cnt_d = 4'd0;
                end
                S_PLUG_FIRST, S_PLUG_SECOND: state_d = exit_state;
                default: ;
            endcase
        end else if (ev_ent) begin
            case (state_q)
                S_IDLE: err_d = 1'b1;
                S_ROT_LOAD: begin
                    rot_we_d  = 1'b1;
                    rot_sel_d = rot_idx_q;
                    rot_pos_d = LET;
                    if (rot_idx_q == LAST_ROT) begin
                        rot_loaded_d = 1'b1;
                        rot_idx_d    = 2'd0;
                        state_d      = S_RUN;
                    end else begin
                        rot_idx_d = rot_idx_q + 2'd1;
                    end
                end
                S_PLUG_FIRST: begin
                    if (let_used) begin
                        err_d = 1'b1;
                    end else begin
                        first_d = LET;
                        state_d = S_PLUG_SECOND;
                    end
                end
                S_PLUG_SECOND: begin
                    if (let_used || LET == first_q) begin
                        err_d = 1'b1;
                    end else begin
                        plug_we_d  = 1'b1;
                        plug_a_d   = first_q;
                        plug_b_d   = LET;
                        used_d     = used_q | let_bit | first_bit;
                        pair_cnt_d = cnt_inc;
                        state_d    = (cnt_inc == MAX_CNT) ? exit_state : S_PLUG_FIRST;
                    end
                end
                S_RUN: begin
                    enc_d     = 1'b1;
                    enc_let_d = LET;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            prev_q       <= '0;
            state_q      <= S_IDLE;
            used_q       <= '0;
            rot_idx_q    <= '0;
            rot_loaded_q <= 1'b0;
            first_q      <= '0;
            pair_cnt_q   <= '0;
            plug_clr_q   <= 1'b0;
            plug_we_q    <= 1'b0;
            plug_a_q     <= '0;
            plug_b_q     <= '0;
            rot_we_q     <= 1'b0;
            rot_sel_q    <= '0;
            rot_pos_q    <= '0;
            enc_q        <= 1'b0;
            enc_let_q    <= '0;
            err_q        <= 1'b0;
        end else begin
            prev_q       <= prev_d;
            state_q      <= state_d;
            used_q       <= used_d;
            rot_idx_q    <= rot_idx_d;
            rot_loaded_q <= rot_loaded_d;
            first_q      <= first_d;
            pair_cnt_q   <= pair_cnt_d;
            plug_clr_q   <= plug_clr_d;
            plug_we_q    <= plug_we_d;
            plug_a_q     <= plug_a_d;
            plug_b_q     <= plug_b_d;
            rot_we_q     <= rot_we_d;
            rot_sel_q    <= rot_sel_d;
            rot_pos_q    <= rot_pos_d;
            enc_q        <= enc_d;
            enc_let_q    <= enc_let_d;
            err_q        <= err_d;
        end
    end

    assign plugClr   = plug_clr_q;
    assign plugWE    = plug_we_q;
    assign plugA     = plug_a_q;
    assign plugB     = plug_b_q;
    assign rotWE     = rot_we_q;
    assign rotSel    = rot_sel_q;
    assign rotPos    = rot_pos_q;
    assign encStrobe = enc_q;
    assign encLet    = enc_let_q;
    assign mode      = state_q;
    assign pairCnt   = pair_cnt_q;
    assign err       = err_q;
endmodule

// File: tb/tb_enigma_config_ctrl.sv
// Directed plus random bench for enigma_config_ctrl with a behavioural reference model.
module tb_enigma_config_ctrl;
    localparam int NUM_ROT   = 3;
    localparam int MAX_PAIRS = 10;

    logic       CLK = 1'b0;
    logic       RST;
    logic [4:0] LET;
    logic       ENTER, LDPlug, LDRot;
    logic       plugClr, plugWE, rotWE, encStrobe, err;
    logic [4:0] plugA, plugB, rotPos, encLet;
    logic [1:0] rotSel;
    logic [2:0] mode;
    logic [3:0] pairCnt;

    enigma_config_ctrl #(.NUM_ROT(NUM_ROT), .MAX_PAIRS(MAX_PAIRS)) dut (
        .CLK(CLK), .RST(RST), .LET(LET), .ENTER(ENTER), .LDPlug(LDPlug), .LDRot(LDRot),
        .plugClr(plugClr), .plugWE(plugWE), .plugA(plugA), .plugB(plugB),
        .rotWE(rotWE), .rotSel(rotSel), .rotPos(rotPos),
        .encStrobe(encStrobe), .encLet(encLet), .mode(mode), .pairCnt(pairCnt), .err(err)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Reference model state: plain integers and a letter-indexed array.
    int m_mode, m_rot_idx, m_first, m_cnt;
    bit m_loaded;
    bit m_used[26];
    bit m_pe, m_pp, m_pr;
    int e_clr, e_pwe, e_pa, e_pb, e_rwe, e_rsel, e_rpos, e_enc, e_elet, e_err;

    // Snapshot of DUT outputs right after a press edge.
    logic [7:0] s_clr, s_pwe, s_pa, s_pb, s_rwe, s_rsel, s_rpos, s_enc, s_err, s_mode, s_cnt;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_rot_idx = 0; m_first = 0; m_cnt = 0; m_loaded = 0;
        for (int i = 0; i < 26; i++) m_used[i] = 0;
        m_pe = 0; m_pp = 0; m_pr = 0;
        e_clr = 0; e_pwe = 0; e_pa = 0; e_pb = 0; e_rwe = 0;
        e_rsel = 0; e_rpos = 0; e_enc = 0; e_elet = 0; e_err = 0;
    endtask

    task automatic enter_plug();
        e_clr = 1; m_cnt = 0; m_mode = 1;
        for (int i = 0; i < 26; i++) m_used[i] = 0;
    endtask

    task automatic model_step(input bit en, input bit lp, input bit lr, input int l);
        bit ee, ep, er;
        ee = en && !m_pe; ep = lp && !m_pp; er = lr && !m_pr;
        m_pe = en; m_pp = lp; m_pr = lr;
        e_clr = 0; e_pwe = 0; e_rwe = 0; e_enc = 0; e_err = 0;
        if (er) begin
            m_mode = 3; m_rot_idx = 0;
        end else if (ep) begin
            if (m_mode == 0 || m_mode == 4) enter_plug();
            else if (m_mode == 1 || m_mode == 2) m_mode = m_loaded ? 4 : 0;
        end else if (ee) begin
            if (m_mode == 0) e_err = 1;
            else if (m_mode == 3) begin
                e_rwe = 1; e_rsel = m_rot_idx; e_rpos = l;
                m_rot_idx++;
                if (m_rot_idx == NUM_ROT) begin
                    m_rot_idx = 0; m_loaded = 1; m_mode = 4;
                end
            end else if (m_mode == 1) begin
                if (m_used[l]) e_err = 1;
                else begin m_first = l; m_mode = 2; end
            end else if (m_mode == 2) begin
                if (m_used[l] || l == m_first) e_err = 1;
                else begin
                    e_pwe = 1; e_pa = m_first; e_pb = l;
                    m_used[m_first] = 1; m_used[l] = 1; m_cnt++;
                    if (m_cnt == MAX_PAIRS) m_mode = m_loaded ? 4 : 0;
                    else m_mode = 1;
                end
            end else begin
                e_enc = 1; e_elet = l;
            end
        end
    endtask

    task automatic check_all();
        check("plugClr", 8'(plugClr), 8'(e_clr));
        check("plugWE", 8'(plugWE), 8'(e_pwe));
        check("plugA", 8'(plugA), 8'(e_pa));
        check("plugB", 8'(plugB), 8'(e_pb));
        check("rotWE", 8'(rotWE), 8'(e_rwe));
        check("rotSel", 8'(rotSel), 8'(e_rsel));
        check("rotPos", 8'(rotPos), 8'(e_rpos));
        check("encStrobe", 8'(encStrobe), 8'(e_enc));
        check("encLet", 8'(encLet), 8'(e_elet));
        check("mode", 8'(mode), 8'(m_mode));
        check("pairCnt", 8'(pairCnt), 8'(m_cnt));
        check("err", 8'(err), 8'(e_err));
    endtask

    task automatic step(input bit en, input bit lp, input bit lr, input int l);
        @(negedge CLK);
        ENTER = en; LDPlug = lp; LDRot = lr; LET = 5'(l);
        model_step(en, lp, lr, l);
        @(posedge CLK);
        #1;
        check_all();
    endtask

    task automatic press(input bit en, input bit lp, input bit lr, input int l);
        step(en, lp, lr, l);
        s_clr = 8'(plugClr); s_pwe = 8'(plugWE); s_pa = 8'(plugA); s_pb = 8'(plugB);
        s_rwe = 8'(rotWE); s_rsel = 8'(rotSel); s_rpos = 8'(rotPos); s_enc = 8'(encStrobe);
        s_err = 8'(err); s_mode = 8'(mode); s_cnt = 8'(pairCnt);
        step(0, 0, 0, l);
    endtask

    task automatic load_rotors(input int a, input int b, input int c);
        press(0, 0, 1, 0);
        press(1, 0, 0, a);
        press(1, 0, 0, b);
        press(1, 0, 0, c);
    endtask

    initial begin
        int enc_seen;
        RST = 1'b1; LET = '0; ENTER = 0; LDPlug = 0; LDRot = 0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        check_all();
        @(negedge CLK);
        RST = 1'b0;

        // ENTER in IDLE is illegal
        press(1, 0, 0, 5);
        check("idle_err", s_err, 8'd1);
        check("idle_mode", s_mode, 8'd0);
        check("idle_noenc", s_enc, 8'd0);

        // Rotor load 3, 7, 20
        press(0, 0, 1, 0);
        check("rot_mode", s_mode, 8'd3);
        press(1, 0, 0, 3);
        check("rot0", {s_rwe[3:0], s_rsel[3:0]}, 8'h10);
        press(1, 0, 0, 7);
        check("rot1_pos", s_rpos, 8'd7);
        press(1, 0, 0, 20);
        check("rot2_sel", s_rsel, 8'd2);
        check("rot2_pos", s_rpos, 8'd20);
        check("run_mode", s_mode, 8'd4);

        // Plug session: pair (0,1)
        press(0, 1, 0, 0);
        check("plug_clr", s_clr, 8'd1);
        press(1, 0, 0, 0);
        press(1, 0, 0, 1);
        check("pair1_we", s_pwe, 8'd1);
        check("pair1_a", s_pa, 8'd0);
        check("pair1_b", s_pb, 8'd1);
        check("pair1_cnt", s_cnt, 8'd1);
        check("pair1_mode", s_mode, 8'd1);

        // Illegal second letters, then pair (2,9)
        press(1, 0, 0, 2);
        press(1, 0, 0, 2);
        check("same_err", s_err, 8'd1);
        press(1, 0, 0, 0);
        check("used_err", s_err, 8'd1);
        press(1, 0, 0, 9);
        check("pair2", {s_pwe[1:0], s_pa[2:0], s_pb[2:0]}, {2'd1, 3'd2, 3'd1});
        check("pair2_b", s_pb, 8'd9);

        // Eight more pairs reach the limit and return to RUN
        for (int p = 0; p < 8; p++) begin
            press(1, 0, 0, 10 + 2 * p);
            press(1, 0, 0, 11 + 2 * p);
        end
        check("max_cnt", s_cnt, 8'd10);
        check("max_mode", s_mode, 8'd4);

        // LDRot and ENTER on the same edge
        press(1, 0, 1, 4);
        check("prio_mode", s_mode, 8'd3);
        check("prio_noenc", s_enc, 8'd0);
        press(1, 0, 0, 1);
        press(1, 0, 0, 2);
        press(1, 0, 0, 3);

        // Held ENTER gives one encrypt request
        enc_seen = 0;
        for (int i = 0; i < 50; i++) begin
            step(1, 0, 0, 17);
            if (encStrobe === 1'b1) enc_seen++;
        end
        step(0, 0, 0, 17);
        check("hold_one_enc", 8'(enc_seen), 8'd1);

        // Reset in the middle of rotor loading
        press(0, 0, 1, 0);
        press(1, 0, 0, 11);
        #2;
        RST = 1'b1;
        #1;
        model_reset();
        check_all();
        @(negedge CLK);
        RST = 1'b0;
        press(1, 0, 0, 6);
        check("post_rst_err", s_err, 8'd1);
        check("post_rst_mode", s_mode, 8'd0);

        // Random walk against the model
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 1) == 0), ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 11) == 0), int'($urandom_range(0, 25)));
        end
        // Random fill of a full plug session after loading rotors
        load_rotors(int'($urandom_range(0, 25)), int'($urandom_range(0, 25)), int'($urandom_range(0, 25)));
        press(0, 1, 0, 0);
        for (int i = 0; i < 200 && m_mode != 4; i++) begin
            press(1, 0, 0, int'($urandom_range(0, 25)));
        end
        check("rand_fill_mode", 8'(mode), 8'd4);
        check("rand_fill_cnt", 8'(pairCnt), 8'd10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
